// File: rtl/csr_pkg.sv
// Shared CSR access codes, machine-mode CSR addresses and the trap sequencer state type.
package csr_pkg;

  localparam logic [1:0] CSR_READ_ONLY = 2'b00;
  localparam logic [1:0] CSR_WRITE     = 2'b01;
  localparam logic [1:0] CSR_SET       = 2'b10;
  localparam logic [1:0] CSR_CLEAR     = 2'b11;

  localparam logic [11:0] MTVEC  = 12'h305;
  localparam logic [11:0] MEPC   = 12'h341;
  localparam logic [11:0] MCAUSE = 12'h342;
  localparam logic [11:0] MTVAL  = 12'h343;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_EPC,
    S_WR_CAUSE,
    S_WR_TVAL,
    S_RD_TVEC,
    S_RD_EPC,
    S_REDIRECT
  } seq_state_e;

endpackage

// File: rtl/csr_trap_sequencer.sv
// Arbitrates the single CSR port between instruction CSR ops and trap entry / MRET sequencing.
// Define CSR_TRAP_MTVAL_EN to add the mtval write step to trap entry.
module csr_trap_sequencer
  import csr_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            trap_req,
  input  logic [XLEN-1:0] trap_cause,
  input  logic [XLEN-1:0] trap_pc,
  input  logic [XLEN-1:0] trap_tval,
  input  logic            mret_req,
  output logic            req_ack,
  input  logic            inst_csr_valid,
  input  logic [11:0]     inst_csr_number,
  input  logic [1:0]      inst_csr_access,
  input  logic [XLEN-1:0] inst_csr_wdata,
  output logic            inst_csr_ready,
  output logic [XLEN-1:0] inst_csr_rdata,
  output logic [11:0]     csr_number,
  output logic [1:0]      csr_access_type,
  output logic [XLEN-1:0] csr_in,
  input  logic [XLEN-1:0] csr_out,
  output logic            busy,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc
);

  localparam logic [XLEN-1:0] ALIGN_MASK = {{(XLEN-2){1'b1}}, 2'b00};

  seq_state_e      state_q;
  logic [XLEN-1:0] cause_q;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] redirect_pc_q;

`ifdef CSR_TRAP_MTVAL_EN
  logic [XLEN-1:0] tval_q;
`else
  logic unused_tval;
  assign unused_tval = ^trap_tval;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      cause_q       <= '0;
      pc_q          <= '0;
      redirect_pc_q <= '0;
`ifdef CSR_TRAP_MTVAL_EN
      tval_q        <= '0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (trap_req) begin
            cause_q <= trap_cause;
            pc_q    <= trap_pc & ALIGN_MASK;
`ifdef CSR_TRAP_MTVAL_EN
            tval_q  <= trap_tval;
`endif
            state_q <= S_WR_EPC;
          end else if (mret_req) begin
            state_q <= S_RD_EPC;
          end
        end
        S_WR_EPC:   state_q <= S_WR_CAUSE;
`ifdef CSR_TRAP_MTVAL_EN
        S_WR_CAUSE: state_q <= S_WR_TVAL;
        S_WR_TVAL:  state_q <= S_RD_TVEC;
`else
        S_WR_CAUSE: state_q <= S_RD_TVEC;
`endif
        // mtvec MODE bits are dropped: only direct mode is supported.
        S_RD_TVEC, S_RD_EPC: begin
          redirect_pc_q <= csr_out & ALIGN_MASK;
          state_q       <= S_REDIRECT;
        end
        S_REDIRECT: state_q <= S_IDLE;
        default:    state_q <= S_IDLE;
      endcase
    end
  end

  // Port drive is decoded from state; the reset gate keeps the CSR file from
  // seeing an instruction write while reset is held in IDLE.
  always_comb begin
    req_ack         = 1'b0;
    inst_csr_ready  = 1'b0;
    csr_number      = '0;
    csr_access_type = CSR_READ_ONLY;
    csr_in          = '0;
    if (!reset) begin
      case (state_q)
        S_IDLE: begin
          if (trap_req || mret_req) begin
            req_ack = 1'b1;
          end else if (inst_csr_valid) begin
            inst_csr_ready  = 1'b1;
            csr_number      = inst_csr_number;
            csr_access_type = inst_csr_access;
            csr_in          = inst_csr_wdata;
          end
        end
        S_WR_EPC: begin
          csr_number      = MEPC;
          csr_access_type = CSR_WRITE;
          csr_in          = pc_q;
        end
        S_WR_CAUSE: begin
          csr_number      = MCAUSE;
          csr_access_type = CSR_WRITE;
          csr_in          = cause_q;
        end
`ifdef CSR_TRAP_MTVAL_EN
        S_WR_TVAL: begin
          csr_number      = MTVAL;
          csr_access_type = CSR_WRITE;
          csr_in          = tval_q;
        end
`endif
        S_RD_TVEC: csr_number = MTVEC;
        S_RD_EPC:  csr_number = MEPC;
        default: ;
      endcase
    end
  end

  assign inst_csr_rdata = csr_out;
  assign busy           = (state_q != S_IDLE);
  assign redirect_valid = (state_q == S_REDIRECT);
  assign redirect_pc    = redirect_pc_q;

endmodule

// File: tb/tb_csr_trap_sequencer.sv
// Directed and randomized checks of csr_trap_sequencer against a per-cycle script model and a CSR file model.
module tb_csr_trap_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        trap_req;
  logic [31:0] trap_cause, trap_pc, trap_tval;
  logic        mret_req;
  logic        req_ack;
  logic        inst_csr_valid;
  logic [11:0] inst_csr_number;
  logic [1:0]  inst_csr_access;
  logic [31:0] inst_csr_wdata;
  logic        inst_csr_ready;
  logic [31:0] inst_csr_rdata;
  logic [11:0] csr_number;
  logic [1:0]  csr_access_type;
  logic [31:0] csr_in;
  logic [31:0] csr_out;
  logic        busy, redirect_valid;
  logic [31:0] redirect_pc;

  csr_trap_sequencer #(.XLEN(32)) dut (
    .clk(clk), .reset(reset),
    .trap_req(trap_req), .trap_cause(trap_cause), .trap_pc(trap_pc), .trap_tval(trap_tval),
    .mret_req(mret_req), .req_ack(req_ack),
    .inst_csr_valid(inst_csr_valid), .inst_csr_number(inst_csr_number),
    .inst_csr_access(inst_csr_access), .inst_csr_wdata(inst_csr_wdata),
    .inst_csr_ready(inst_csr_ready), .inst_csr_rdata(inst_csr_rdata),
    .csr_number(csr_number), .csr_access_type(csr_access_type), .csr_in(csr_in),
    .csr_out(csr_out), .busy(busy), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  always #5 clk = ~clk;

  // CSR register file stand-in.
  logic [31:0] mem [0:4095];
  assign csr_out = mem[csr_number];
  always @(posedge clk) begin
    case (csr_access_type)
      2'b01: mem[csr_number] <= csr_in;
      2'b10: mem[csr_number] <= mem[csr_number] | csr_in;
      2'b11: mem[csr_number] <= mem[csr_number] & ~csr_in;
      default: ;
    endcase
  end

  // Reference model: a queue of what each remaining busy cycle must look like.
  typedef struct {
    logic [11:0] num;
    logic [1:0]  acc;
    logic [31:0] data;
    int          kind;   // 0 port op, 1 read captured as redirect target, 2 redirect
  } item_t;
  item_t       q[$];
  logic [31:0] exp_rpc;
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic item_t mk(input logic [11:0] n, input logic [1:0] a, input logic [31:0] d, input int k);
    item_t it;
    it.num = n; it.acc = a; it.data = d; it.kind = k;
    return it;
  endfunction

  task automatic step();
    logic [11:0] en; logic [1:0] ea; logic [31:0] ei;
    logic eack, erdy, ebusy, erv;
    logic drop_trap, drop_mret, drop_inst;
    item_t it;
    @(negedge clk);
    en = 0; ea = 0; ei = 0; eack = 0; erdy = 0; ebusy = 0; erv = 0;
    drop_trap = 0; drop_mret = 0; drop_inst = 0;
    if (reset) begin
      q.delete();
      chk("rst_redirect_pc", redirect_pc, 32'h0);
    end else if (q.size() > 0) begin
      it = q.pop_front();
      ebusy = 1;
      if (it.kind == 2) begin
        erv = 1;
        chk("redirect_pc", redirect_pc, exp_rpc);
      end else begin
        en = it.num; ea = it.acc; ei = it.data;
        if (it.kind == 1) exp_rpc = mem[it.num] & 32'hFFFF_FFFC;
      end
    end else if (trap_req) begin
      eack = 1; drop_trap = 1;
      q.push_back(mk(12'h341, 2'b01, trap_pc & 32'hFFFF_FFFC, 0));
      q.push_back(mk(12'h342, 2'b01, trap_cause, 0));
`ifdef CSR_TRAP_MTVAL_EN
      q.push_back(mk(12'h343, 2'b01, trap_tval, 0));
`endif
      q.push_back(mk(12'h305, 2'b00, 32'h0, 1));
      q.push_back(mk(12'h000, 2'b00, 32'h0, 2));
    end else if (mret_req) begin
      eack = 1; drop_mret = 1;
      q.push_back(mk(12'h341, 2'b00, 32'h0, 1));
      q.push_back(mk(12'h000, 2'b00, 32'h0, 2));
    end else if (inst_csr_valid) begin
      erdy = 1; drop_inst = 1;
      en = inst_csr_number; ea = inst_csr_access; ei = inst_csr_wdata;
      chk("inst_rdata", inst_csr_rdata, mem[inst_csr_number]);
    end
    chk("busy", {31'b0, busy}, {31'b0, ebusy});
    chk("req_ack", {31'b0, req_ack}, {31'b0, eack});
    chk("inst_ready", {31'b0, inst_csr_ready}, {31'b0, erdy});
    chk("redirect_valid", {31'b0, redirect_valid}, {31'b0, erv});
    chk("csr_number", {20'b0, csr_number}, {20'b0, en});
    chk("csr_access", {30'b0, csr_access_type}, {30'b0, ea});
    chk("csr_in", csr_in, ei);
    @(posedge clk); #1;
    if (drop_trap) trap_req = 0;
    if (drop_mret) mret_req = 0;
    if (drop_inst) inst_csr_valid = 0;
  endtask

  task automatic inst(input logic [11:0] n, input logic [1:0] a, input logic [31:0] d);
    inst_csr_valid = 1; inst_csr_number = n; inst_csr_access = a; inst_csr_wdata = d;
  endtask

  task automatic trap(input logic [31:0] pc, input logic [31:0] cause, input logic [31:0] tval);
    trap_req = 1; trap_pc = pc; trap_cause = cause; trap_tval = tval;
  endtask

  function automatic logic [11:0] rnd_addr();
    logic [11:0] tbl [5];
    tbl[0] = 12'h305; tbl[1] = 12'h341; tbl[2] = 12'h342; tbl[3] = 12'h343; tbl[4] = 12'h300;
    return tbl[$urandom_range(0, 4)];
  endfunction

  logic [31:0] saved_cause;
  int rv_count = 0;
  always @(posedge clk) if (redirect_valid) rv_count <= rv_count + 1;

  initial begin
    foreach (mem[i]) mem[i] = 32'h0;
    reset = 1; trap_req = 0; mret_req = 0; inst_csr_valid = 0;
    trap_cause = 0; trap_pc = 0; trap_tval = 0;
    inst_csr_number = 0; inst_csr_access = 0; inst_csr_wdata = 0;
    step(); step();
    reset = 0;
    step();

    // Instruction write to mtvec, then read back.
    inst(12'h305, 2'b01, 32'h8000_0100);
    step();
    inst(12'h305, 2'b00, 32'h0);
    #2 chk("mtvec_readback", inst_csr_rdata, 32'h8000_0100);
    step();

    // Trap entry with a misaligned mtvec mode field.
    inst(12'h305, 2'b01, 32'h8000_0103);
    step();
    trap(32'h0000_1006, 32'h2, 32'hDEAD_BEEF);
    repeat (7) step();
    chk("mepc_written", mem[12'h341], 32'h0000_1004);
    chk("mcause_written", mem[12'h342], 32'h2);
    chk("trap_target", redirect_pc, 32'h8000_0100);
`ifdef CSR_TRAP_MTVAL_EN
    chk("mtval_written", mem[12'h343], 32'hDEAD_BEEF);
`endif

    // MRET.
    inst(12'h341, 2'b01, 32'h0000_2000);
    step();
    mret_req = 1;
    repeat (4) step();
    chk("mret_target", redirect_pc, 32'h0000_2000);

    // All three requests at once: trap first, then mret, then instruction.
    trap(32'h0000_3000, 32'hB, 32'h1234);
    mret_req = 1;
    inst(12'h342, 2'b10, 32'hF0);
    repeat (10) step();

    // Reset during WR_CAUSE abandons the sequence.
    inst(12'h342, 2'b01, 32'h5A5A_0000);
    step();
    saved_cause = mem[12'h342];
    trap(32'h0000_4000, 32'h7, 32'h0);
    step(); step();
    rv_count = 0;
    #2 reset = 1;
    #1 chk("async_rst_busy", {31'b0, busy}, 32'h0);
    chk("async_rst_access", {30'b0, csr_access_type}, 32'h0);
    step(); step();
    reset = 0;
    repeat (4) step();
    chk("no_mcause_write", mem[12'h342], saved_cause);
    chk("no_redirect_after_rst", rv_count, 0);

    // Randomized traffic.
    for (int c = 0; c < 800; c++) begin
      if (!trap_req && $urandom_range(0, 9) == 0)
        trap($urandom, $urandom, $urandom);
      if (!mret_req && $urandom_range(0, 11) == 0)
        mret_req = 1;
      if (!inst_csr_valid && $urandom_range(0, 2) == 0)
        inst(rnd_addr(), 2'($urandom_range(0, 3)), $urandom);
      step();
    end
    trap_req = 0; mret_req = 0; inst_csr_valid = 0;
    repeat (8) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
